mod_up_counter: RTL and testbench
=================================

// Module: mod_up_counter
//
// PURPOSE
//   Synchronous, parameterised, programmable-modulus UP counter. It is the
//   ascending companion of the team's down counter.
//   - Counts 0 -> limit, then wraps to 0.
//   - Provides synchronous load, count enable, a terminal-count pulse and a
//     sticky overflow flag.
//   - Used as a timebase, prescaler or cascade stage in the sequential
//     counter library.
//
// PARAMETERS
//   N        4          counter width in bits (N >= 1)
//   RST_VAL  0          value loaded into q on reset (must be <= 2^N-1)
//
// PORTS
//   clk       in   1   clock, all state updates on posedge
//   rst       in   1   reset, synchronous, active-high
//   en        in   1   count enable; one increment per enabled cycle
//   load      in   1   synchronous load strobe
//   load_val  in   N   value taken on load
//   limit     in   N   terminal value (modulus = limit+1); sampled every cycle
//   clr_ovf   in   1   clears the sticky ovf flag
//   q         out  N   current count (registered)
//   tc        out  1   terminal-count pulse (registered, 1 cycle)
//   ovf       out  1   sticky wrap/overflow flag (registered)
//
// BEHAVIOUR
//   Reset
//   - Reset (rst=1 at posedge): q=RST_VAL, tc=0, ovf=0.
//   - Reset overrides every other input, including mid-count and mid-load.
//
//   Per-edge priority: rst > load > en > hold
//   - load=1:
//     - q <= min(load_val, limit).
//     - tc <= 0; ovf is unchanged (load never sets it).
//     - en is ignored that cycle.
//   - en=1, load=0, q <  limit: q <= q+1, tc <= 0.
//   - en=1, load=0, q >= limit (wrap event):
//     - q <= 0, tc <= 1, ovf <= 1.
//     - Because the test is >=, lowering limit below the current q wraps on
//       the next enabled cycle. The counter never runs past limit.
//   - en=0, load=0: q holds; tc <= 0.
//
//   Outputs and flags
//   - tc is high for exactly the one cycle after a wrap edge, coincident
//     with q==0.
//   - Back-to-back wraps (limit==0, en held high) keep tc high continuously
//     and hold q at 0.
//   - ovf clears when clr_ovf=1. If a wrap and clr_ovf occur on the same
//     edge, the set wins (ovf=1).
//
//   Arithmetic and latency
//   - Arithmetic is modulo 2^N. With limit = 2^N-1 the counter behaves as a
//     free-running binary up counter.
//   - Latency is one cycle from input to q/tc/ovf. There are no
//     combinational paths from inputs to outputs.
//
// CONFIGURATION
//   UPCNT_SAT_EN (defined): saturating mode.
//   - At en=1 with q >= limit: q <= limit (hold; clamps if limit was lowered).
//   - tc is asserted only on the 1st edge reaching saturation, i.e. on the
//     increment from limit-1 to limit.
//   - ovf sets on every enabled cycle attempted while already at limit.
//   - Only load or rst leaves saturation.
//   UPCNT_SAT_EN (undefined): wrap behaviour as above. This is the default.
//
// TESTING  (N=4 unless noted; wrap build unless noted)
//   1. rst=1 2 cycles, then en=1, limit=15 -> q counts 0,1..15,0.
//      tc=1 only with the q=0 after 15; ovf=1 thereafter.
//   2. limit=5, en=1 from q=0 -> q 0..5,0..5. tc pulses every 6 cycles.
//      clr_ovf=1 on a non-wrap cycle -> ovf=0 next cycle.
//   3. q=9, load=1 load_val=3 with en=1 -> q=3, tc=0.
//      Then load_val=12 with limit=7 -> q=7 (clamped).
//   4. q=10, limit changed to 4, en=1 -> next q=0, tc=1.
//      limit=0 with en held -> q stays 0, tc stays 1.
//   5. Wrap and clr_ovf on the same edge -> ovf=1.
//      rst mid-count at q=6 -> q=0, tc=0, ovf=0 next cycle.
//   6. UPCNT_SAT_EN, limit=3, en=1 -> q 0,1,2,3,3,3.
//      tc=1 only when q becomes 3; ovf=1 from the 2nd 3 onward.
//      load_val=0 -> counting resumes.

Source files
------------

// File: rtl/mod_up_counter.sv
// Programmable-modulus up counter with synchronous load, terminal-count pulse and sticky overflow.
// Define UPCNT_SAT_EN to build the saturating variant; the default build wraps to 0 after limit.
module mod_up_counter #(
    parameter int N       = 4,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic [N-1:0] limit,
    input  logic         clr_ovf,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         ovf
);

    localparam logic [N-1:0] LP_RST_Q = RST_VAL[N-1:0];

    logic [N-1:0] r_q;
    logic         r_tc;
    logic         r_ovf;

    logic [N-1:0] w_q_inc;
    logic [N-1:0] w_load_q;
    logic         w_at_limit;

    assign w_q_inc    = r_q + 1'b1;
    assign w_load_q   = (load_val > limit) ? limit : load_val;
    // >= so that lowering limit below the current count is caught on the next enabled edge
    assign w_at_limit = (r_q >= limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= LP_RST_Q;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (load) begin
            r_q  <= w_load_q;
            r_tc <= 1'b0;
            if (clr_ovf) r_ovf <= 1'b0;
        end else if (en) begin
`ifdef UPCNT_SAT_EN
            if (w_at_limit) begin
                r_q   <= limit;
                r_tc  <= 1'b0;
                r_ovf <= 1'b1;
            end else begin
                r_q  <= w_q_inc;
                r_tc <= (w_q_inc == limit);
                if (clr_ovf) r_ovf <= 1'b0;
            end
`else
            if (w_at_limit) begin
                r_q   <= '0;
                r_tc  <= 1'b1;
                r_ovf <= 1'b1;
            end else begin
                r_q  <= w_q_inc;
                r_tc <= 1'b0;
                if (clr_ovf) r_ovf <= 1'b0;
            end
`endif
        end else begin
            r_tc <= 1'b0;
            if (clr_ovf) r_ovf <= 1'b0;
        end
    end

    assign q   = r_q;
    assign tc  = r_tc;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_mod_up_counter.sv
// Directed self-checking bench for mod_up_counter (N=4, RST_VAL=0).
// Saturating-mode scenario runs only when UPCNT_SAT_EN is defined.
module tb_mod_up_counter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         load;
    logic [N-1:0] load_val;
    logic [N-1:0] limit;
    logic         clr_ovf;
    logic [N-1:0] q;
    logic         tc;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    mod_up_counter #(.N(N), .RST_VAL(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .clr_ovf  (clr_ovf),
        .q        (q),
        .tc       (tc),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Advance one active edge and settle; inputs are changed only after this returns.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b0; load_val = '0; limit = 4'd15; clr_ovf = 1'b0;
        tick(); tick();
        checks++; if (q !== 4'd0)  begin errors++; $display("FAIL reset_q got=%0d exp=0", q); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", tc); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_free_run();
        logic [N-1:0] exp_q;
        logic exp_tc, exp_ovf;
        rst = 1'b0; en = 1'b1; limit = 4'd15;
        exp_ovf = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            tick();
            exp_q  = 4'(i % 16);
            exp_tc = (i == 16);
            if (i == 16) exp_ovf = 1'b1;
            checks++; if (q !== exp_q) begin errors++; $display("FAIL free_q step=%0d got=%0d exp=%0d", i, q, exp_q); end
            checks++; if (tc !== exp_tc) begin errors++; $display("FAIL free_tc step=%0d got=%b exp=%b", i, tc, exp_tc); end
            checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL free_ovf step=%0d got=%b exp=%b", i, ovf, exp_ovf); end
        end
        // q is now 2; hold with en low
        en = 1'b0;
        tick(); tick();
        checks++; if (q !== 4'd2) begin errors++; $display("FAIL hold_q got=%0d exp=2", q); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL hold_tc got=%b exp=0", tc); end
    endtask

    task automatic test_mod6();
        logic [N-1:0] exp_q;
        logic exp_tc;
        // bring q to 0 via load
        load = 1'b1; load_val = 4'd0; tick(); load = 1'b0;
        limit = 4'd5; en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_q  = 4'(i % 6);
            exp_tc = (i % 6 == 0);
            checks++; if (q !== exp_q) begin errors++; $display("FAIL mod6_q step=%0d got=%0d exp=%0d", i, q, exp_q); end
            checks++; if (tc !== exp_tc) begin errors++; $display("FAIL mod6_tc step=%0d got=%b exp=%b", i, tc, exp_tc); end
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL mod6_ovf got=%b exp=1", ovf); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++; if (q !== 4'd1) begin errors++; $display("FAIL clr_q got=%0d exp=1", q); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got=%b exp=0", ovf); end
        tick();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf_stay got=%b exp=0", ovf); end
    endtask

    task automatic test_load();
        en = 1'b0; limit = 4'd15;
        load = 1'b1; load_val = 4'd9; tick();
        checks++; if (q !== 4'd9) begin errors++; $display("FAIL load9_q got=%0d exp=9", q); end
        en = 1'b1; load_val = 4'd3; tick();
        checks++; if (q !== 4'd3) begin errors++; $display("FAIL load3_q got=%0d exp=3", q); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL load3_tc got=%b exp=0", tc); end
        load_val = 4'd12; limit = 4'd7; tick();
        checks++; if (q !== 4'd7) begin errors++; $display("FAIL load_clamp_q got=%0d exp=7", q); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL load_ovf got=%b exp=0", ovf); end
        load = 1'b0; tick();
        checks++; if (q !== 4'd0 || tc !== 1'b1) begin errors++; $display("FAIL clamp_wrap q=%0d tc=%b exp q=0 tc=1", q, tc); end
    endtask

    task automatic test_limit_lower();
        en = 1'b0; limit = 4'd15; load = 1'b1; load_val = 4'd10; tick(); load = 1'b0;
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++; if (q !== 4'd10 || ovf !== 1'b0) begin errors++; $display("FAIL prep10 q=%0d ovf=%b exp q=10 ovf=0", q, ovf); end
        limit = 4'd4; en = 1'b1; tick();
        checks++; if (q !== 4'd0) begin errors++; $display("FAIL lower_q got=%0d exp=0", q); end
        checks++; if (tc !== 1'b1) begin errors++; $display("FAIL lower_tc got=%b exp=1", tc); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL lower_ovf got=%b exp=1", ovf); end
        limit = 4'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (q !== 4'd0) begin errors++; $display("FAIL lim0_q step=%0d got=%0d exp=0", i, q); end
            checks++; if (tc !== 1'b1) begin errors++; $display("FAIL lim0_tc step=%0d got=%b exp=1", i, tc); end
        end
        en = 1'b0; tick();
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL lim0_stop_tc got=%b exp=0", tc); end
    endtask

    task automatic test_wrap_clr_same_edge();
        en = 1'b0; limit = 4'd2; load = 1'b1; load_val = 4'd2; clr_ovf = 1'b1; tick();
        load = 1'b0;
        checks++; if (q !== 4'd2 || ovf !== 1'b0) begin errors++; $display("FAIL prep2 q=%0d ovf=%b exp q=2 ovf=0", q, ovf); end
        en = 1'b1; clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++; if (q !== 4'd0 || tc !== 1'b1) begin errors++; $display("FAIL wclr_wrap q=%0d tc=%b exp q=0 tc=1", q, tc); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL wclr_ovf got=%b exp=1", ovf); end
    endtask

    task automatic test_rst_mid();
        en = 1'b0; limit = 4'd15; load = 1'b1; load_val = 4'd0; tick(); load = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (q !== 4'd6 || ovf !== 1'b1) begin errors++; $display("FAIL mid6 q=%0d ovf=%b exp q=6 ovf=1", q, ovf); end
        rst = 1'b1; load = 1'b1; load_val = 4'd9; tick();
        rst = 1'b0; load = 1'b0; en = 1'b0;
        checks++; if (q !== 4'd0) begin errors++; $display("FAIL rstmid_q got=%0d exp=0", q); end
        checks++; if (tc !== 1'b0) begin errors++; $display("FAIL rstmid_tc got=%b exp=0", tc); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got=%b exp=0", ovf); end
    endtask

`ifdef UPCNT_SAT_EN
    task automatic test_saturate();
        logic [N-1:0] exp_q [5] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
        logic         exp_tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic         exp_ov[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        rst = 1'b1; tick(); rst = 1'b0;
        limit = 4'd3; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL sat_q step=%0d got=%0d exp=%0d", i, q, exp_q[i]); end
            checks++; if (tc !== exp_tc[i]) begin errors++; $display("FAIL sat_tc step=%0d got=%b exp=%b", i, tc, exp_tc[i]); end
            checks++; if (ovf !== exp_ov[i]) begin errors++; $display("FAIL sat_ovf step=%0d got=%b exp=%b", i, ovf, exp_ov[i]); end
        end
        load = 1'b1; load_val = 4'd0; tick(); load = 1'b0;
        tick();
        checks++; if (q !== 4'd1) begin errors++; $display("FAIL sat_resume_q got=%0d exp=1", q); end
        en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_mod6();
        test_load();
        test_limit_lower();
        test_wrap_clr_same_edge();
        test_rst_mid();
`ifdef UPCNT_SAT_EN
        test_saturate();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
